// File: rtl/fdiv_ctrl.sv
// fdiv_ctrl -- run-time programmable clock-divider controller.
//
// Produces a registered divided clock clk_out from clk_in with equal high
// and low phases of active_half cycles each. Divisor changes and start/stop
// are sequenced so that every output period completes: there are no runt
// high or low phases.
//
// Ports:
//   clk_in    in   1      sole clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   run       in   1      1 = generate clk_out, 0 = stop after current period
//   cfg_half  in   CNT_W  requested half-period in clk_in cycles (divisor = 2*cfg_half)
//   cfg_valid in   1      cfg_half is valid
//   cfg_ready out  1      controller can accept a configuration (= !pend_vld)
//   clk_out   out  1      divided clock, registered
//   tick      out  1      one-cycle pulse coincident with each clk_out rising edge
//   cfg_err   out  1      one-cycle pulse after a zero cfg_half was consumed
//   busy      out  1      high whenever the controller is not idle
//
// Handshake: a configuration transfers on any rising edge where
// cfg_valid && cfg_ready. A zero value is consumed and discarded (cfg_err
// pulses the following cycle). While idle a value goes straight into
// active_half; while running it is parked in pend_half and takes effect at
// the next period boundary, with cfg_ready low until then.
//
// Build option: define FDIV_CTRL_TICK_EN to include the tick register.
// Without it, tick is tied to 0 and clk_out is unaffected.

module fdiv_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DIV_DEFAULT / 2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] active_half, active_half_nxt;
    logic [CNT_W-1:0] pend_half, pend_half_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             clk_out_nxt;
    logic             cfg_err_nxt;

    logic             xfer;
    logic             xfer_ok;
    logic             phase_end;

    assign cfg_ready = !pend_vld;
    assign busy      = (state != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    assign xfer_ok   = xfer && (cfg_half != '0);
    // active_half is never zero (zero configurations are rejected), so the
    // subtraction cannot underflow.
    assign phase_end = (cnt == active_half - ONE);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            active_half <= HALF_RST;
            pend_half   <= '0;
            pend_vld    <= 1'b0;
            clk_out     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            active_half <= active_half_nxt;
            pend_half   <= pend_half_nxt;
            pend_vld    <= pend_vld_nxt;
            clk_out     <= clk_out_nxt;
            cfg_err     <= cfg_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        active_half_nxt = active_half;
        pend_half_nxt   = pend_half;
        pend_vld_nxt    = pend_vld;
        clk_out_nxt     = clk_out;
        cfg_err_nxt     = xfer && (cfg_half == '0);

        case (state)
            IDLE: begin
                clk_out_nxt = 1'b0;
                // Written before the run check so that a value arriving in
                // the same cycle as run already governs the first period.
                if (xfer_ok) begin
                    active_half_nxt = cfg_half;
                end
                if (run) begin
                    state_nxt   = HIGH;
                    clk_out_nxt = 1'b1;
                    cnt_nxt     = '0;
                end
            end

            HIGH: begin
                if (phase_end) begin
                    state_nxt   = LOW;
                    clk_out_nxt = 1'b0;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
                if (xfer_ok) begin
                    pend_half_nxt = cfg_half;
                    pend_vld_nxt  = 1'b1;
                end
            end

            LOW: begin
                if (phase_end) begin
                    if (pend_vld) begin
                        active_half_nxt = pend_half;
                        pend_vld_nxt    = 1'b0;
                    end
                    cnt_nxt = '0;
                    if (run) begin
                        state_nxt   = HIGH;
                        clk_out_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
                // A transfer is only possible while pend_vld is 0, so it never
                // collides with the boundary clear above; one accepted on the
                // boundary cycle waits for the following boundary.
                if (xfer_ok) begin
                    pend_half_nxt = cfg_half;
                    pend_vld_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                clk_out_nxt = 1'b0;
                cnt_nxt     = '0;
            end
        endcase
    end

`ifdef FDIV_CTRL_TICK_EN
    logic tick_nxt;

    // HIGH is only ever entered from IDLE or LOW, i.e. on a clk_out rise.
    assign tick_nxt = (state_nxt == HIGH) && (state != HIGH);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tick <= 1'b0;
        end else begin
            tick <= tick_nxt;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule
